i2c_cmd_sequencer: RTL and testbench
====================================

I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000, meaning WAIT-state watchdog limit in i_sclk cycles (used only with I2C_SEQ_TIMEOUT_EN).
REQ-003 i_sclk  input  1  single system clock; all state changes on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_cmd_valid  input  1  host command offered.
REQ-006 o_cmd_ready  output  1  FIFO can accept a command.
REQ-007 i_cmd_addr  input  7  target slave address.
REQ-008 i_cmd_r_w  input  1  1 = read, 0 = write.
REQ-009 i_cmd_wdata  input  8  write byte (ignored for reads).
REQ-010 o_address_out  output  7  address to master i_address_in.
REQ-011 o_address_r_w  output  1  direction to master i_address_r_w.
REQ-012 o_sdata_out  output  8  write byte to master i_sdata_in.
REQ-013 o_start  output  1  one-cycle transaction start pulse to master.
REQ-014 i_busy  input  1  master transaction in progress.
REQ-015 i_done  input  1  one-cycle master completion pulse.
REQ-016 i_rdata  input  8  byte read by master, valid with i_done.
REQ-017 i_nack  input  1  slave NACK flag, valid with i_done.
REQ-018 o_rsp_valid / i_rsp_ready  output/input  1/1  response handshake.
REQ-019 o_rsp_data  output  8  read byte (0x00 for writes).
REQ-020 o_rsp_nack  output  1  transaction NACKed.
REQ-021 o_rsp_timeout  output  1  transaction timed out.
REQ-022 o_level  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-023 o_idle  output  1  FSM in IDLE and FIFO empty.

Function
REQ-024 Command entry = {addr, r_w, wdata}, 16 bits; push when i_cmd_valid && o_cmd_ready; o_cmd_ready = (o_level < DEPTH), registered-state based, no combinational path from i_cmd_valid.
REQ-025 FSM states: IDLE, ISSUE, WAIT, RESP; encoding free.
REQ-026 IDLE -> ISSUE when FIFO non-empty, !i_busy and !o_rsp_valid.
REQ-027 ISSUE (exactly one cycle): o_start = 1, load o_address_out/o_address_r_w/o_sdata_out from FIFO head, pop head, -> WAIT.
REQ-028 o_address_out, o_address_r_w, o_sdata_out hold last issued values until next ISSUE.
REQ-029 WAIT: on i_done capture i_rdata (reads) or 0x00 (writes) and i_nack, -> RESP; i_done outside WAIT ignored.
REQ-030 RESP: o_rsp_valid = 1, data/flags stable until i_rsp_ready sampled high; then -> IDLE next cycle.
REQ-031 Start-to-start minimum spacing: ISSUE, WAIT >= 1 cycle, RESP >= 1 cycle, IDLE 1 cycle.
REQ-032 Simultaneous push and pop in ISSUE: o_level unchanged; push at full refused (ready low), entry not lost on host side.
REQ-033 Pointers wrap modulo DEPTH; FIFO order strictly preserved.
REQ-034 NACKed commands not retried; next queued command proceeds normally.

Reset
REQ-035 i_rst_n low: FSM IDLE, FIFO empty (o_level = 0), all outputs 0 except o_cmd_ready = 1 and o_idle = 1, immediately and asynchronously.
REQ-036 Reset mid-transaction discards queued commands and pending response; no o_start until a new push after release.

Configuration
REQ-037 Macro I2C_SEQ_TIMEOUT_EN defined: WAIT counts cycles; at TIMEOUT_CYCLES without i_done -> RESP with o_rsp_timeout = 1, o_rsp_data = 0x00, o_rsp_nack = 0; counter clears on WAIT entry.
REQ-038 Macro undefined: no counter, WAIT unbounded, o_rsp_timeout tied 0.

Verification
REQ-039 Push write {0x59, 0, 0xAA}, model done after 20 cycles with nack = 0 -> one o_start, o_address_out = 0x59, o_sdata_out = 0xAA, response data 0x00, nack 0.
REQ-040 Push read {0x59, 1}, model returns 0xAA -> o_rsp_data = 0xAA, o_rsp_valid held until i_rsp_ready.
REQ-041 Push 5 commands back-to-back, DEPTH = 4, master stalled -> o_cmd_ready low after 4th accepted push, 5th accepted after first ISSUE, all issued in order.
REQ-042 Model returns nack = 1 on first of two commands -> o_rsp_nack = 1 then second command issues normally.
REQ-043 Assert i_rst_n low during WAIT with 3 queued -> o_level = 0, o_start never pulses afterwards without new push.
REQ-044 With I2C_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES = 50, no i_done -> o_rsp_timeout = 1 exactly 50 cycles after WAIT entry.

Source files
------------

// File: rtl/i2c_cmd_sequencer_if.sv
// Host-side command/response bus plus the byte-level I2C master hookup for i2c_cmd_sequencer.
// slave = sequencer view; master = host and I2C master view.
interface i2c_cmd_sequencer_if #(
  parameter int DEPTH = 4
);
  // host command channel
  logic                   i_cmd_valid;
  logic                   o_cmd_ready;
  logic [6:0]             i_cmd_addr;
  logic                   i_cmd_r_w;
  logic [7:0]             i_cmd_wdata;

  // byte-level I2C master
  logic [6:0]             o_address_out;
  logic                   o_address_r_w;
  logic [7:0]             o_sdata_out;
  logic                   o_start;
  logic                   i_busy;
  logic                   i_done;
  logic [7:0]             i_rdata;
  logic                   i_nack;

  // host response channel and status
  logic                   o_rsp_valid;
  logic                   i_rsp_ready;
  logic [7:0]             o_rsp_data;
  logic                   o_rsp_nack;
  logic                   o_rsp_timeout;
  logic [$clog2(DEPTH):0] o_level;
  logic                   o_idle;

  modport slave (
    input  i_cmd_valid, i_cmd_addr, i_cmd_r_w, i_cmd_wdata,
    output o_cmd_ready,
    output o_address_out, o_address_r_w, o_sdata_out, o_start,
    input  i_busy, i_done, i_rdata, i_nack,
    output o_rsp_valid, o_rsp_data, o_rsp_nack, o_rsp_timeout,
    input  i_rsp_ready,
    output o_level, o_idle
  );

  modport master (
    output i_cmd_valid, i_cmd_addr, i_cmd_r_w, i_cmd_wdata,
    input  o_cmd_ready,
    input  o_address_out, o_address_r_w, o_sdata_out, o_start,
    output i_busy, i_done, i_rdata, i_nack,
    input  o_rsp_valid, o_rsp_data, o_rsp_nack, o_rsp_timeout,
    output i_rsp_ready,
    input  o_level, o_idle
  );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Queues host I2C commands in a DEPTH-entry FIFO and runs them one at a time through a byte-level master.
// Optional WAIT watchdog: define I2C_SEQ_TIMEOUT_EN to bound WAIT at TIMEOUT_CYCLES.
module i2c_cmd_sequencer #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               i_sclk,
  input  logic               i_rst_n,
  i2c_cmd_sequencer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_nxt;

  // command FIFO: entry = {addr[6:0], r_w, wdata[7:0]}
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [15:0]   head;
  logic          cmd_ready;
  logic          push;
  logic          pop;

  logic [6:0]    addr_q;
  logic          r_w_q;
  logic [7:0]    wdata_q;
  logic [7:0]    rsp_data_q;
  logic          rsp_nack_q;
  logic          rsp_timeout_q;

  logic          load_cmd;
  logic          capture_done;
  logic          capture_timeout;
  logic          timeout_hit;
  logic          rsp_valid;

  // ready depends only on registered occupancy, never on i_cmd_valid
  assign cmd_ready = (level < LW'(DEPTH));
  assign push      = bus.i_cmd_valid && cmd_ready;
  assign pop       = (state_q == S_ISSUE);
  assign head      = mem[rd_ptr];
  assign rsp_valid = (state_q == S_RESP);

  always_ff @(posedge i_sclk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.i_cmd_addr, bus.i_cmd_r_w, bus.i_cmd_wdata};
    end
  end

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;

  // cleared while issuing so every WAIT starts counting from zero
  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt <= '0;
    end else if (state_q == S_ISSUE) begin
      wait_cnt <= '0;
    end else if (state_q == S_WAIT) begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  end

  assign timeout_hit = (state_q == S_WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  // watchdog compiled out: WAIT only ends on i_done, TIMEOUT_CYCLES has no effect
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state_q;
    load_cmd        = 1'b0;
    capture_done    = 1'b0;
    capture_timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((level != '0) && !bus.i_busy && !rsp_valid) begin
          state_nxt = S_ISSUE;
          load_cmd  = 1'b1;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_done) begin
          state_nxt    = S_RESP;
          capture_done = 1'b1;
        end else if (timeout_hit) begin
          state_nxt       = S_RESP;
          capture_timeout = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.i_rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // head is latched on the way into ISSUE so the master sees it alongside o_start
  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      r_w_q   <= 1'b0;
      wdata_q <= '0;
    end else if (load_cmd) begin
      addr_q  <= head[15:9];
      r_w_q   <= head[8];
      wdata_q <= head[7:0];
    end
  end

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_data_q    <= '0;
      rsp_nack_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else if (capture_done) begin
      rsp_data_q    <= r_w_q ? bus.i_rdata : 8'h00;
      rsp_nack_q    <= bus.i_nack;
      rsp_timeout_q <= 1'b0;
    end else if (capture_timeout) begin
      rsp_data_q    <= 8'h00;
      rsp_nack_q    <= 1'b0;
      rsp_timeout_q <= 1'b1;
    end
  end

  assign bus.o_cmd_ready   = cmd_ready;
  assign bus.o_address_out = addr_q;
  assign bus.o_address_r_w = r_w_q;
  assign bus.o_sdata_out   = wdata_q;
  assign bus.o_start       = (state_q == S_ISSUE);
  assign bus.o_rsp_valid   = rsp_valid;
  assign bus.o_rsp_data    = rsp_data_q;
  assign bus.o_rsp_nack    = rsp_nack_q;
  assign bus.o_rsp_timeout = rsp_timeout_q;
  assign bus.o_level       = level;
  assign bus.o_idle        = (state_q == S_IDLE) && (level == '0);

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Scoreboard bench for i2c_cmd_sequencer: host driver, behavioural I2C master and response monitor
// run as separate processes sharing expected-command and expected-response queues.
module tb_i2c_cmd_sequencer;
  localparam int DEPTH  = 4;
  localparam int TO_CYC = 50;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  i2c_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

  i2c_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .i_sclk (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct packed {logic [6:0] addr; logic rw; logic [7:0] wdata;} cmd_t;
  typedef struct packed {logic [7:0] data; logic nack; logic tmo;} rsp_t;
  typedef struct {int delay; logic [7:0] rdata; logic nack;} plan_t;

  cmd_t  exp_cmd[$];
  rsp_t  exp_rsp[$];
  plan_t plan[$];

  int   total = 0;
  int   bad   = 0;
  int   n_starts = 0;
  int   n_rsp    = 0;
  int   n_push   = 0;
  int   accept_starts = 0;
  logic model_busy = 1'b0;
  logic hold_busy  = 1'b0;
  logic no_done    = 1'b0;
  logic rsp_stall  = 1'b0;

  assign bus.i_busy = model_busy | hold_busy;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  // Behavioural master: checks each issued command, then answers after a planned or random delay.
  initial begin : master_model
    bit    active;
    int    cnt;
    logic  [7:0] rd;
    logic  nk;
    cmd_t  c;
    plan_t p;
    active = 0; cnt = 0; rd = '0; nk = 1'b0;
    bus.i_done = 1'b0; bus.i_rdata = '0; bus.i_nack = 1'b0;
    forever begin
      @(negedge clk);
      bus.i_done  = 1'b0;
      bus.i_rdata = 8'($urandom);
      bus.i_nack  = 1'($urandom);
      if (!rst_n) begin
        active = 0;
        model_busy = 1'b0;
        exp_cmd.delete();
        exp_rsp.delete();
        plan.delete();
      end else begin
        if (active) begin
          if (cnt == 0) begin
            bus.i_done  = 1'b1;
            bus.i_rdata = rd;
            bus.i_nack  = nk;
            active      = 0;
            model_busy  = 1'b0;
          end else begin
            cnt--;
          end
        end
        if (bus.o_start) begin
          n_starts++;
          check("start_while_busy", 32'(active), 0);
          c = {bus.o_address_out, bus.o_address_r_w, bus.o_sdata_out};
          if (exp_cmd.size() == 0) begin
            total++; bad++;
            $display("FAIL start_unexpected: got cmd 0x%0h, required no start", c);
          end else begin
            check("start_cmd", 32'(c), 32'(exp_cmd.pop_front()));
          end
          if (plan.size() != 0) begin
            p = plan.pop_front();
          end else begin
            p.delay = $urandom_range(0, 15);
            p.rdata = 8'($urandom);
            p.nack  = ($urandom_range(0, 3) == 0);
          end
          if (no_done) begin
`ifdef I2C_SEQ_TIMEOUT_EN
            exp_rsp.push_back({8'h00, 1'b0, 1'b1});
`endif
          end else begin
            active = 1; cnt = p.delay; rd = p.rdata; nk = p.nack;
            model_busy = 1'b1;
            exp_rsp.push_back({c.rw ? p.rdata : 8'h00, p.nack, 1'b0});
          end
        end
      end
    end
  end

  // Response monitor: random ready, hold-stability checks, scoreboard pop on handshake.
  initial begin : rsp_monitor
    rsp_t cur, prev;
    bit   prev_vld, prev_hs;
    logic r;
    prev = '0; prev_vld = 0; prev_hs = 0;
    bus.i_rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_vld = 0; prev_hs = 0;
        bus.i_rsp_ready = 1'b0;
      end else begin
        cur = {bus.o_rsp_data, bus.o_rsp_nack, bus.o_rsp_timeout};
        if (prev_vld && !prev_hs) begin
          check("rsp_hold_vld", 32'(bus.o_rsp_valid), 1);
          check("rsp_hold_dat", 32'(cur), 32'(prev));
        end
        r = rsp_stall ? 1'b0 : ($urandom_range(0, 9) < 7);
        bus.i_rsp_ready = r;
        if (bus.o_rsp_valid && r) begin
          n_rsp++;
          if (exp_rsp.size() == 0) begin
            total++; bad++;
            $display("FAIL rsp_unexpected: got rsp 0x%0h, required none", cur);
          end else begin
            check("rsp", 32'(cur), 32'(exp_rsp.pop_front()));
          end
        end
        prev_vld = bus.o_rsp_valid;
        prev_hs  = bus.o_rsp_valid && r;
        prev     = cur;
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push_cmd(input logic [6:0] a, input logic rw, input logic [7:0] d);
    int n = 0;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_addr  = a;
    bus.i_cmd_r_w   = rw;
    bus.i_cmd_wdata = d;
    while (!bus.o_cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", 32'(bus.o_cmd_ready), 1);
    if (bus.o_cmd_ready) begin
      exp_cmd.push_back({a, rw, d});
      accept_starts = n_starts;
      n_push++;
    end
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_cmd.size() != 0 || exp_rsp.size() != 0 || !bus.o_idle) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 32'(n < 3000), 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int s0, n;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_addr  = '0;
    bus.i_cmd_r_w   = 1'b0;
    bus.i_cmd_wdata = '0;

    #2 rst_n = 1'b0;
    #2;
    check("rst_level", 32'(bus.o_level), 0);
    check("rst_ready", 32'(bus.o_cmd_ready), 1);
    check("rst_idle",  32'(bus.o_idle), 1);
    check("rst_outs",  32'({bus.o_start, bus.o_rsp_valid, bus.o_address_out, bus.o_address_r_w,
                            bus.o_sdata_out, bus.o_rsp_data, bus.o_rsp_nack, bus.o_rsp_timeout}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single write, master answers after 20 cycles
    s0 = n_starts;
    plan.push_back('{20, 8'h5A, 1'b0});
    push_cmd(7'h59, 1'b0, 8'hAA);
    drain("wr");
    check("wr_one_start", 32'(n_starts - s0), 1);

    // read returning 0xAA, response held while ready is low
    rsp_stall = 1'b1;
    plan.push_back('{5, 8'hAA, 1'b0});
    push_cmd(7'h59, 1'b1, 8'h00);
    n = 0;
    while (!bus.o_rsp_valid && n < 100) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    check("rd_valid_held", 32'(bus.o_rsp_valid), 1);
    check("rd_data_held",  32'(bus.o_rsp_data), 32'h0000_00AA);
    rsp_stall = 1'b0;
    drain("rd");

    // NACK on the first of two commands, second proceeds
    plan.push_back('{3, 8'h11, 1'b1});
    plan.push_back('{3, 8'h22, 1'b0});
    push_cmd(7'h10, 1'b1, 8'h00);
    push_cmd(7'h11, 1'b1, 8'h00);
    drain("nack");

    // five back-to-back pushes with the master stalled
    hold_busy = 1'b1;
    s0 = n_starts;
    for (int i = 0; i < 4; i++) push_cmd(7'(8'h20 + i), 1'b0, 8'(i * 17));
    check("full_ready", 32'(bus.o_cmd_ready), 0);
    check("full_level", 32'(bus.o_level), DEPTH);
    fork
      push_cmd(7'h24, 1'b1, 8'h00);
      begin
        repeat (4) @(negedge clk);
        check("stall_no_start", 32'(n_starts - s0), 0);
        hold_busy = 1'b0;
      end
    join
    check("fifth_after_issue", 32'(accept_starts > s0), 1);
    drain("full");

    // reset while one command is in WAIT and three are queued
    no_done = 1'b1;
    s0 = n_starts;
    for (int i = 0; i < 4; i++) push_cmd(7'($urandom), 1'($urandom), 8'($urandom));
    repeat (3) @(negedge clk);
    check("pre_rst_level",  32'(bus.o_level), 3);
    check("pre_rst_starts", 32'(n_starts - s0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_level", 32'(bus.o_level), 0);
    check("mid_rst_flags", 32'({bus.o_start, bus.o_rsp_valid, bus.o_cmd_ready, bus.o_idle}), 32'b0011);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    no_done = 1'b0;
    s0 = n_starts;
    repeat (30) @(negedge clk);
    check("no_start_after_rst", 32'(n_starts - s0), 0);
    check("idle_after_rst", 32'(bus.o_idle), 1);

`ifdef I2C_SEQ_TIMEOUT_EN
    no_done = 1'b1;
    push_cmd(7'h33, 1'b1, 8'h00);
    n = 0;
    while (!bus.o_start && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (!bus.o_rsp_valid && n < 200) begin @(negedge clk); n++; end
    check("timeout_latency", 32'(n), TO_CYC + 1);
    check("timeout_flag", 32'(bus.o_rsp_timeout), 1);
    no_done = 1'b0;
    drain("tmo");
`endif

    // randomized traffic
    repeat (40) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push_cmd(7'($urandom), 1'($urandom), 8'($urandom));
    end
    drain("rand");
    check("end_level", 32'(bus.o_level), 0);
    check("end_ready", 32'(bus.o_cmd_ready), 1);
    check("rsp_count", 32'(n_rsp), 32'(n_push - 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
